// File: rtl/axi_arbiter_2to1_if.sv
// One AXI4 port (AR/R/AW/W/B) as seen between a cache master and the arbiter, or between the arbiter and memory.
// Single ID, no RREADY/BREADY: responses are always accepted.
interface axi_arbiter_2to1_if;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;

    modport master (
        output araddr, arlen, arvalid,
        input  arready,
        input  rdata, rresp, rlast, rvalid,
        output awaddr, awlen, awvalid,
        input  awready,
        output wdata, wlast, wvalid,
        input  wready,
        input  bresp, bvalid
    );

    modport slave (
        input  araddr, arlen, arvalid,
        output arready,
        output rdata, rresp, rlast, rvalid,
        input  awaddr, awlen, awvalid,
        output awready,
        input  wdata, wlast, wvalid,
        output wready,
        output bresp, bvalid
    );
endinterface

// File: rtl/axi_arbiter_2to1.sv
// Two-master to one-slave AXI4 arbiter with independent read and write arbitration, grant held per burst.
// Define AXI_ARB_FIXED_PRIO_EN for fixed priority (S0 wins); otherwise round-robin seeded by INIT_LAST.
module axi_arbiter_2to1 #(
    parameter logic INIT_LAST = 1'b1
) (
    input  logic                      CLK,
    input  logic                      RSTN,
    axi_arbiter_2to1_if.slave         s0_axi,
    axi_arbiter_2to1_if.slave         s1_axi,
    axi_arbiter_2to1_if.master        m_axi,
    output logic [2:0]                M_AXI_ARSIZE,
    output logic [2:0]                M_AXI_AWSIZE,
    output logic [1:0]                M_AXI_ARBURST,
    output logic [1:0]                M_AXI_AWBURST,
    output logic [3:0]                M_AXI_WSTRB
);

    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_BUSY, W_RESP} w_state_t;

    r_state_t r_state, r_state_next;
    w_state_t w_state, w_state_next;
    logic     rgnt, rgnt_next;
    logic     wgnt, wgnt_next;
`ifndef AXI_ARB_FIXED_PRIO_EN
    logic     rlast, rlast_next;
    logic     wlast, wlast_next;
`endif
    logic     aw_done, aw_done_next;
    logic     w_done, w_done_next;

    logic     ar_sel_valid;
    logic     aw_sel_valid;
    logic     w_sel_valid;
    logic     aw_fwd;
    logic     w_fwd;
    logic     aw_hs;
    logic     w_last_hs;

    assign M_AXI_ARSIZE  = 3'b010;
    assign M_AXI_AWSIZE  = 3'b010;
    assign M_AXI_ARBURST = 2'b01;
    assign M_AXI_AWBURST = 2'b01;
    assign M_AXI_WSTRB   = 4'b1111;

    assign m_axi.araddr = rgnt ? s1_axi.araddr : s0_axi.araddr;
    assign m_axi.arlen  = rgnt ? s1_axi.arlen  : s0_axi.arlen;
    assign m_axi.awaddr = wgnt ? s1_axi.awaddr : s0_axi.awaddr;
    assign m_axi.awlen  = wgnt ? s1_axi.awlen  : s0_axi.awlen;
    assign m_axi.wdata  = wgnt ? s1_axi.wdata  : s0_axi.wdata;
    assign m_axi.wlast  = wgnt ? s1_axi.wlast  : s0_axi.wlast;

    assign s0_axi.rdata = m_axi.rdata;
    assign s1_axi.rdata = m_axi.rdata;
    assign s0_axi.rresp = m_axi.rresp;
    assign s1_axi.rresp = m_axi.rresp;
    assign s0_axi.bresp = m_axi.bresp;
    assign s1_axi.bresp = m_axi.bresp;

    assign ar_sel_valid = rgnt ? s1_axi.arvalid : s0_axi.arvalid;
    assign aw_sel_valid = wgnt ? s1_axi.awvalid : s0_axi.awvalid;
    assign w_sel_valid  = wgnt ? s1_axi.wvalid  : s0_axi.wvalid;

    // Once a channel's part of the burst is done, its VALID is masked so the slave never sees a duplicate.
    assign aw_fwd    = (w_state == W_BUSY) && aw_sel_valid && !aw_done;
    assign w_fwd     = (w_state == W_BUSY) && w_sel_valid && !w_done;
    assign aw_hs     = aw_fwd && m_axi.awready;
    assign w_last_hs = w_fwd && m_axi.wready && m_axi.wlast;

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_state <= R_IDLE;
            w_state <= W_IDLE;
            rgnt    <= 1'b0;
            wgnt    <= 1'b0;
`ifndef AXI_ARB_FIXED_PRIO_EN
            rlast   <= INIT_LAST;
            wlast   <= INIT_LAST;
`endif
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            r_state <= r_state_next;
            w_state <= w_state_next;
            rgnt    <= rgnt_next;
            wgnt    <= wgnt_next;
`ifndef AXI_ARB_FIXED_PRIO_EN
            rlast   <= rlast_next;
            wlast   <= wlast_next;
`endif
            aw_done <= aw_done_next;
            w_done  <= w_done_next;
        end
    end

    always_comb begin
        r_state_next   = r_state;
        rgnt_next      = rgnt;
`ifndef AXI_ARB_FIXED_PRIO_EN
        rlast_next     = rlast;
`endif
        m_axi.arvalid  = 1'b0;
        s0_axi.arready = 1'b0;
        s1_axi.arready = 1'b0;
        s0_axi.rvalid  = 1'b0;
        s1_axi.rvalid  = 1'b0;
        s0_axi.rlast   = 1'b0;
        s1_axi.rlast   = 1'b0;
        case (r_state)
            R_IDLE: begin
                if (s0_axi.arvalid && s1_axi.arvalid) begin
`ifdef AXI_ARB_FIXED_PRIO_EN
                    rgnt_next  = 1'b0;
`else
                    rgnt_next  = ~rlast;
                    rlast_next = ~rlast;
`endif
                    r_state_next = R_ADDR;
                end else if (s0_axi.arvalid) begin
                    rgnt_next    = 1'b0;
                    r_state_next = R_ADDR;
                end else if (s1_axi.arvalid) begin
                    rgnt_next    = 1'b1;
                    r_state_next = R_ADDR;
                end
            end
            R_ADDR: begin
                m_axi.arvalid = ar_sel_valid;
                if (rgnt) s1_axi.arready = m_axi.arready;
                else      s0_axi.arready = m_axi.arready;
                if (ar_sel_valid && m_axi.arready) r_state_next = R_DATA;
                else if (!ar_sel_valid)            r_state_next = R_IDLE;
            end
            R_DATA: begin
                if (rgnt) begin
                    s1_axi.rvalid = m_axi.rvalid;
                    s1_axi.rlast  = m_axi.rlast;
                end else begin
                    s0_axi.rvalid = m_axi.rvalid;
                    s0_axi.rlast  = m_axi.rlast;
                end
                if (m_axi.rvalid && m_axi.rlast) r_state_next = R_IDLE;
            end
            default: r_state_next = R_IDLE;
        endcase
    end

    // W beats may arrive before AW is accepted, so each channel completes independently before the response.
    always_comb begin
        w_state_next   = w_state;
        wgnt_next      = wgnt;
`ifndef AXI_ARB_FIXED_PRIO_EN
        wlast_next     = wlast;
`endif
        aw_done_next   = aw_done;
        w_done_next    = w_done;
        m_axi.awvalid  = aw_fwd;
        m_axi.wvalid   = w_fwd;
        s0_axi.awready = 1'b0;
        s1_axi.awready = 1'b0;
        s0_axi.wready  = 1'b0;
        s1_axi.wready  = 1'b0;
        s0_axi.bvalid  = 1'b0;
        s1_axi.bvalid  = 1'b0;
        case (w_state)
            W_IDLE: begin
                if (s0_axi.awvalid || s1_axi.awvalid) begin
                    aw_done_next = 1'b0;
                    w_done_next  = 1'b0;
                    w_state_next = W_BUSY;
                end
                if (s0_axi.awvalid && s1_axi.awvalid) begin
`ifdef AXI_ARB_FIXED_PRIO_EN
                    wgnt_next  = 1'b0;
`else
                    wgnt_next  = ~wlast;
                    wlast_next = ~wlast;
`endif
                end else if (s0_axi.awvalid) begin
                    wgnt_next = 1'b0;
                end else if (s1_axi.awvalid) begin
                    wgnt_next = 1'b1;
                end
            end
            W_BUSY: begin
                if (wgnt) begin
                    s1_axi.awready = m_axi.awready && !aw_done;
                    s1_axi.wready  = m_axi.wready && !w_done;
                end else begin
                    s0_axi.awready = m_axi.awready && !aw_done;
                    s0_axi.wready  = m_axi.wready && !w_done;
                end
                aw_done_next = aw_done || aw_hs;
                w_done_next  = w_done || w_last_hs;
                if ((aw_done || aw_hs) && (w_done || w_last_hs)) w_state_next = W_RESP;
            end
            W_RESP: begin
                if (wgnt) s1_axi.bvalid = m_axi.bvalid;
                else      s0_axi.bvalid = m_axi.bvalid;
                if (m_axi.bvalid) w_state_next = W_IDLE;
            end
            default: w_state_next = W_IDLE;
        endcase
    end

endmodule

// File: doc/axi_arbiter_2to1.md
Name: axi_arbiter_2to1

Overview:
- Two-master to one-slave AXI4 arbiter. It shares the single M_AXI port between the instruction-side cache (S0) and the data-side cache (S1).
- Read (AR/R) and write (AW/W/B) paths are arbitrated independently. Each grant is held for one whole burst.
- Round-robin on contention.
- Sits between the cache_axi instances and the external memory interconnect. Single AXI ID; responses are accepted unconditionally, so there is no RREADY/BREADY.

Parameters:
- INIT_LAST, 1'b1: value of the read and write last-grant registers after reset. 1 means S0 wins the first contended arbitration.

Ports:
- CLK  in  1  clock for all logic.
- RSTN  in  1  asynchronous, active-low reset.
- S{n}_AXI_ARADDR / M_AXI_ARADDR  in/out  32  read address; M side driven from the granted master.
- S{n}_AXI_ARLEN / M_AXI_ARLEN  in/out  8  read burst length, forwarded.
- S{n}_AXI_ARVALID / M_AXI_ARVALID  in/out  1  read address valid.
- S{n}_AXI_ARREADY / M_AXI_ARREADY  out/in  1  read address ready.
- S{n}_AXI_RDATA / M_AXI_RDATA  out/in  32  read data, broadcast to both masters.
- S{n}_AXI_RRESP / M_AXI_RRESP  out/in  2  read response, broadcast.
- S{n}_AXI_RLAST / M_AXI_RLAST  out/in  1  last beat, gated to the granted master.
- S{n}_AXI_RVALID / M_AXI_RVALID  out/in  1  read valid, gated to the granted master.
- S{n}_AXI_AWADDR / M_AXI_AWADDR  in/out  32  write address.
- S{n}_AXI_AWLEN / M_AXI_AWLEN  in/out  8  write burst length, forwarded.
- S{n}_AXI_AWVALID / M_AXI_AWVALID  in/out  1  write address valid.
- S{n}_AXI_AWREADY / M_AXI_AWREADY  out/in  1  write address ready.
- S{n}_AXI_WDATA / M_AXI_WDATA  in/out  32  write data.
- S{n}_AXI_WLAST / M_AXI_WLAST  in/out  1  last write beat.
- S{n}_AXI_WVALID / M_AXI_WVALID  in/out  1  write valid.
- S{n}_AXI_WREADY / M_AXI_WREADY  out/in  1  write ready.
- S{n}_AXI_BRESP / M_AXI_BRESP  out/in  2  write response, broadcast.
- S{n}_AXI_BVALID / M_AXI_BVALID  out/in  1  write response valid, gated.
- M_AXI_ARSIZE / M_AXI_AWSIZE / M_AXI_ARBURST / M_AXI_AWBURST / M_AXI_WSTRB  out  3/3/2/2/4  tied to 3'b010 / 3'b010 / 2'b01 / 2'b01 / 4'b1111.
- n = 0 (S0, instruction cache), 1 (S1, data cache).

Behaviour:
- Reset (RSTN=0, asynchronous):
  - Both FSMs go to IDLE; last-grant registers load INIT_LAST.
  - All M_AXI_*VALID and all S{n}_*READY/*VALID outputs are 0.
  - Address and data muxes select S0.
- Read FSM, states R_IDLE, R_ADDR, R_DATA:
  - R_IDLE, no ARVALID: stay in R_IDLE.
  - R_IDLE, exactly one ARVALID: register that master as rgnt and go to R_ADDR.
  - R_IDLE, both ARVALID: grant the master != rlast, go to R_ADDR, and set rlast = rgnt.
  - Arbitration latency is one cycle, from ARVALID sampled in R_IDLE to M_AXI_ARVALID high.
- Read address phase, R_ADDR:
  - M_AXI_ARADDR/ARLEN come from S[rgnt].
  - M_AXI_ARVALID = S[rgnt]_ARVALID.
  - S[rgnt]_ARREADY = M_AXI_ARREADY; the other master's ARREADY = 0.
  - On the ARVALID&&ARREADY handshake, go to R_DATA.
  - If S[rgnt] drops ARVALID before the handshake, return to R_IDLE.
- Read data phase, R_DATA:
  - S[rgnt]_RVALID = M_AXI_RVALID and S[rgnt]_RLAST = M_AXI_RLAST; the other master's RVALID/RLAST = 0.
  - RDATA and RRESP go to both masters unmasked.
  - M_AXI_RVALID&&M_AXI_RLAST: go to R_IDLE.
- Write FSM, states W_IDLE, W_BUSY, W_RESP:
  - Arbitration in W_IDLE uses AWVALID, with the same rules and its own wlast register.
  - W_IDLE to W_BUSY clears the aw_done and w_done flags.
- Write busy phase, W_BUSY:
  - AW is muxed from S[wgnt] as for AR.
  - The W channel is muxed from S[wgnt] concurrently, so W beats may precede the AW handshake; the non-granted master's WREADY = 0.
  - The AW handshake sets aw_done; the WVALID&&WREADY&&WLAST handshake sets w_done.
  - Go to W_RESP when both flags are set, counting either flag's handshake in the current cycle.
  - AWVALID is not forwarded once aw_done is set; WVALID is not forwarded once w_done is set.
- Write response phase, W_RESP:
  - S[wgnt]_BVALID = M_AXI_BVALID.
  - M_AXI_BVALID: go to W_IDLE.
- Independence: read and write may be granted to different masters at the same time.
- Back-to-back: after returning to IDLE, a master still asserting VALID is re-arbitrated next cycle. With both requesting, grants alternate S0, S1, S0, ...
- Grant hold: a master's 32-burst page refill is interleaved per burst with the other master's bursts; the grant is never pre-empted mid-burst.
- Reset mid-burst: the FSM aborts immediately. The downstream slave and the masters are reset by the same RSTN.

Optional Feature:
- AXI_ARB_FIXED_PRIO_EN defined: both arbiters use fixed priority, S0 always wins on contention. Last-grant registers and INIT_LAST are unused.
- Undefined: round-robin as above.

Test Plan:
- Lone S0 read: S0 ARVALID, ARADDR=0x0000_1000, ARLEN=0x1f -> M_AXI_ARVALID the next cycle with the same address; 32 beats delivered to S0 only; S1_RVALID stays 0; R_IDLE after RLAST.
- Contended reads: S0 and S1 ARVALID in the same cycle after reset -> S0 granted first (INIT_LAST=1), S1 second; a persistent re-request alternates S0/S1 per burst.
- Concurrent read and write: S0 reads 0x2000 while S1 writes 0x3000 -> both channels proceed in parallel; S1 gets BVALID, S0 gets all RVALID.
- Write data before address: S1 drives 32 W beats (WLAST on beat 32) while the slave holds AWREADY=0 for 40 cycles -> W_RESP is entered only after the AW handshake, and BVALID is forwarded to S1.
- Mid-burst reset: RSTN low during beat 10 of a read -> all VALID/READY outputs 0 asynchronously; after release both FSMs are IDLE and a new S1 request is granted.
- AXI_ARB_FIXED_PRIO_EN defined with both masters continuously requesting -> S0 always granted.
